// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the keyboard/ball datapath and the Pong match sequencer.
// frame_tick is a one-cycle strobe with no back-pressure; every sequencer output is a registered level.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic [7:0] keycode;
  logic [9:0] BallX;
  logic       ball_reset;
  logic       ball_run;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [2:0] state;
  logic [1:0] winner;
  logic [7:0] frame_cnt;

  modport master (
    output frame_tick, keycode, BallX,
    input  ball_reset, ball_run, serve_dir, score1, score2, state, winner, frame_cnt
  );

  modport slave (
    input  frame_tick, keycode, BallX,
    output ball_reset, ball_run, serve_dir, score1, score2, state, winner, frame_cnt
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/rally/pause/point/over flow, goal detection, scores and winner.
// frame_cnt is exported on the bundle as a debug view of the post-goal hold counter.
module pong_match_ctrl #(
  parameter logic [7:0] SERVE_KEY    = 8'h2C,
  parameter logic [7:0] PAUSE_KEY    = 8'h13,
  parameter logic [9:0] LEFT_GOAL    = 10'd38,
  parameter logic [9:0] RIGHT_GOAL   = 10'd591,
  parameter logic [7:0] POINT_FRAMES = 8'd60,
  parameter logic [3:0] WIN_SCORE    = 4'd7
) (
  input logic              Clk,
  input logic              Reset,
  pong_match_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t     st;
  logic [7:0] prev_key;
  logic       key_arm;
  logic       ball_reset_r;
  logic       ball_run_r;
  logic       serve_dir_r;
  logic [3:0] score1_r;
  logic [3:0] score2_r;
  logic [1:0] winner_r;
  logic [7:0] frame_cnt_r;

  // key_arm masks the first cycle after reset so a key held through reset
  // is absorbed into prev_key instead of producing an event.
  logic serve_ev;
  logic pause_ev;
  assign serve_ev = key_arm && (bus.keycode == SERVE_KEY) && (prev_key != SERVE_KEY);
  assign pause_ev = key_arm && (bus.keycode == PAUSE_KEY) && (prev_key != PAUSE_KEY);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st           <= IDLE;
      prev_key     <= 8'h00;
      key_arm      <= 1'b0;
      ball_reset_r <= 1'b1;
      ball_run_r   <= 1'b0;
      serve_dir_r  <= 1'b0;
      score1_r     <= 4'd0;
      score2_r     <= 4'd0;
      winner_r     <= 2'b00;
      frame_cnt_r  <= 8'd0;
    end else begin
      prev_key <= bus.keycode;
      key_arm  <= 1'b1;
      case (st)
        IDLE: begin
          if (serve_ev) st <= SERVE;
        end
        SERVE: begin
          if (bus.frame_tick) begin
            st           <= RALLY;
            ball_reset_r <= 1'b0;
            ball_run_r   <= 1'b1;
          end
        end
        RALLY: begin
          // A goal on this tick takes precedence over a coincident pause press.
          if (bus.frame_tick && (bus.BallX <= LEFT_GOAL)) begin
            score2_r    <= (score2_r == 4'hF) ? 4'hF : score2_r + 4'd1;
            serve_dir_r <= 1'b0;
            frame_cnt_r <= 8'd0;
            ball_run_r  <= 1'b0;
            st          <= POINT;
          end else if (bus.frame_tick && (bus.BallX >= RIGHT_GOAL)) begin
            score1_r    <= (score1_r == 4'hF) ? 4'hF : score1_r + 4'd1;
            serve_dir_r <= 1'b1;
            frame_cnt_r <= 8'd0;
            ball_run_r  <= 1'b0;
            st          <= POINT;
          end else if (pause_ev) begin
            ball_run_r <= 1'b0;
            st         <= PAUSE;
          end
        end
        PAUSE: begin
          if (pause_ev) begin
            ball_run_r <= 1'b1;
            st         <= RALLY;
          end
        end
        POINT: begin
          if (bus.frame_tick) begin
            if (frame_cnt_r == POINT_FRAMES - 8'd1) begin
              frame_cnt_r  <= 8'd0;
              ball_reset_r <= 1'b1;
              if (score1_r == WIN_SCORE) begin
                winner_r <= 2'b01;
                st       <= OVER;
              end else if (score2_r == WIN_SCORE) begin
                winner_r <= 2'b10;
                st       <= OVER;
              end else begin
                st <= SERVE;
              end
            end else begin
              frame_cnt_r <= frame_cnt_r + 8'd1;
            end
          end
        end
        OVER: begin
          if (serve_ev) begin
            score1_r    <= 4'd0;
            score2_r    <= 4'd0;
            winner_r    <= 2'b00;
            serve_dir_r <= 1'b0;
            st          <= SERVE;
          end
        end
        default: begin
          st           <= IDLE;
          ball_reset_r <= 1'b1;
          ball_run_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state      = st;
  assign bus.ball_reset = ball_reset_r;
  assign bus.ball_run   = ball_run_r;
  assign bus.serve_dir  = serve_dir_r;
  assign bus.score1     = score1_r;
  assign bus.score2     = score2_r;
  assign bus.winner     = winner_r;
  assign bus.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: scenario tasks push expected output
// vectors to exp_q as stimulus is driven and pop them when the DUT settles.
module tb_pong_match_ctrl;

  localparam int W = 16;

  logic Clk;
  logic Reset;
  pong_match_ctrl_if bus ();

  pong_match_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock/reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;
  logic [W-1:0] want;
  int n_chk;
  int n_fail;
  int m_s1;
  int m_s2;

  // Packed view of the visible outputs: {state, ball_reset, ball_run, serve_dir, score1, score2, winner}.
  function automatic logic [W-1:0] pk(input logic [2:0] st, input logic br, input logic run,
                                      input logic sd, input int s1, input int s2,
                                      input logic [1:0] w);
    pk = {st, br, run, sd, s1[3:0], s2[3:0], w};
  endfunction

  function automatic logic [W-1:0] obs();
    obs = {bus.state, bus.ball_reset, bus.ball_run, bus.serve_dir,
           bus.score1, bus.score2, bus.winner};
  endfunction

  // Driver tasks
  task automatic tick_clk();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    tick_clk();
    bus.frame_tick = 1'b0;
    tick_clk();
  endtask

  task automatic press(input logic [7:0] k);
    bus.keycode = k;
    tick_clk();
    bus.keycode = 8'h00;
    tick_clk();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.keycode = 8'h2C;
    exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 2'b00));
    tick_clk();
    tick_clk();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL reset_state got=%h want=%h", got, want); end
    exp_q.push_back(16'd0);
    got = {8'd0, bus.frame_cnt}; want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL reset_frame_cnt got=%h want=%h", got, want); end
    // Space held across reset release, plus ticks and P in IDLE: nothing moves.
    Reset = 1'b0;
    exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 2'b00));
    tick_clk();
    frame();
    bus.keycode = 8'h00;
    press(8'h13);
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL held_key_through_reset got=%h want=%h", got, want); end
  endtask

  task automatic test_serve();
    exp_q.push_back(pk(3'd1, 1'b1, 1'b0, 1'b0, 0, 0, 2'b00));
    bus.keycode = 8'h2C;
    tick_clk();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL serve_latency got=%h want=%h", got, want); end
    exp_q.push_back(pk(3'd1, 1'b1, 1'b0, 1'b0, 0, 0, 2'b00));
    tick_clk();
    tick_clk();
    bus.keycode = 8'h00;
    tick_clk();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL serve_held_key got=%h want=%h", got, want); end
    exp_q.push_back(pk(3'd2, 1'b0, 1'b1, 1'b0, 0, 0, 2'b00));
    frame();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL serve_to_rally got=%h want=%h", got, want); end
  endtask

  task automatic test_left_goal();
    bus.BallX = 10'd30;
    m_s2++;
    exp_q.push_back(pk(3'd4, 1'b0, 1'b0, 1'b0, m_s1, m_s2, 2'b00));
    frame();
    bus.BallX = 10'd300;
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL left_goal got=%h want=%h", got, want); end
    exp_q.push_back(pk(3'd4, 1'b0, 1'b0, 1'b0, m_s1, m_s2, 2'b00));
    repeat (59) frame();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL point_hold_59 got=%h want=%h", got, want); end
    exp_q.push_back(pk(3'd1, 1'b1, 1'b0, 1'b0, m_s1, m_s2, 2'b00));
    frame();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL point_hold_60 got=%h want=%h", got, want); end
    frame();
  endtask

  task automatic test_right_goal_priority();
    bus.BallX = 10'd600;
    bus.keycode = 8'h13;
    m_s1++;
    exp_q.push_back(pk(3'd4, 1'b0, 1'b0, 1'b1, m_s1, m_s2, 2'b00));
    bus.frame_tick = 1'b1;
    tick_clk();
    bus.frame_tick = 1'b0;
    bus.keycode = 8'h00;
    bus.BallX = 10'd300;
    tick_clk();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL right_goal_over_pause got=%h want=%h", got, want); end
    exp_q.push_back(pk(3'd2, 1'b0, 1'b1, 1'b1, m_s1, m_s2, 2'b00));
    repeat (60) frame();
    frame();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL right_goal_reserve got=%h want=%h", got, want); end
  endtask

  task automatic test_pause();
    exp_q.push_back(pk(3'd3, 1'b0, 1'b0, 1'b1, m_s1, m_s2, 2'b00));
    press(8'h13);
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL pause_enter got=%h want=%h", got, want); end
    exp_q.push_back(pk(3'd3, 1'b0, 1'b0, 1'b1, m_s1, m_s2, 2'b00));
    bus.BallX = 10'd10;
    repeat (5) frame();
    press(8'h2C);
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL pause_ignores_goal got=%h want=%h", got, want); end
    bus.BallX = 10'($urandom_range(100, 500));
    exp_q.push_back(pk(3'd2, 1'b0, 1'b1, 1'b1, m_s1, m_s2, 2'b00));
    press(8'h13);
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL pause_exit got=%h want=%h", got, want); end
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 6; i++) begin
      bus.BallX = 10'($urandom_range(591, 1023));
      m_s1++;
      exp_q.push_back(pk(3'd4, 1'b0, 1'b0, 1'b1, m_s1, m_s2, 2'b00));
      frame();
      bus.BallX = 10'($urandom_range(39, 590));
      got = obs(); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL goal_%0d got=%h want=%h", i, got, want); end
      repeat (60) frame();
      if (i < 5) frame();
    end
    exp_q.push_back(pk(3'd5, 1'b1, 1'b0, 1'b1, 7, m_s2, 2'b01));
    repeat (3) frame();
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL game_over got=%h want=%h", got, want); end
    m_s1 = 0;
    m_s2 = 0;
    exp_q.push_back(pk(3'd1, 1'b1, 1'b0, 1'b0, 0, 0, 2'b00));
    press(8'h2C);
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL restart got=%h want=%h", got, want); end
  endtask

  task automatic test_reset_mid_point();
    frame();
    bus.BallX = 10'd38;
    frame();
    bus.BallX = 10'd300;
    exp_q.push_back(16'd20);
    repeat (20) frame();
    got = {8'd0, bus.frame_cnt}; want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL point_frame_cnt got=%h want=%h", got, want); end
    exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 2'b00));
    exp_q.push_back(16'd0);
    Reset = 1'b1;
    bus.frame_tick = 1'b1;
    tick_clk();
    Reset = 1'b0;
    bus.frame_tick = 1'b0;
    got = obs(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL mid_point_reset got=%h want=%h", got, want); end
    got = {8'd0, bus.frame_cnt}; want = exp_q.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL mid_point_reset_cnt got=%h want=%h", got, want); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_s1 = 0;
    m_s2 = 0;
    Reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.keycode = 8'h00;
    bus.BallX = 10'd300;
    test_reset();
    test_serve();
    test_left_goal();
    test_right_goal_priority();
    test_pause();
    test_game_over();
    test_reset_mid_point();
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong datapath. It owns the game flow around the ball and paddle motion logic: idle, serve, rally, pause, point and game over. It holds the ball at centre or gates its frame updates, detects goals from the ball's X position, keeps both scores, and declares a winner. It sits between the keyboard keycode path and the ball module, and its outputs also drive the score and banner display logic.

## Interface
Parameters:
- SERVE_KEY, 8'h2C: keycode that serves or restarts (space).
- PAUSE_KEY, 8'h13: keycode that toggles pause (P).
- LEFT_GOAL, 10'd38: BallX at or below this value scores for player 2.
- RIGHT_GOAL, 10'd591: BallX at or above this value scores for player 1.
- POINT_FRAMES, 8'd60: frames the ball stays frozen after a goal. Legal range is 1–255.
- WIN_SCORE, 4'd7: score that ends the match.

Ports:
- Clk, input, 1: system clock. This is the only clock.
- Reset, input, 1: synchronous, active-high reset.
- frame_tick, input, 1: one-Clk-wide strobe, once per video frame.
- keycode, input, 8: current keyboard keycode. 8'h00 means no key.
- BallX, input, 10: ball centre X position.
- ball_reset, output, 1: level signal. While high, the ball module is held at centre.
- ball_run, output, 1: level signal. The ball advances only on frames where frame_tick & ball_run.
- serve_dir, output, 1: 0 = serve toward the right, 1 = serve toward the left.
- score1, output, 4: player 1 score.
- score2, output, 4: player 2 score.
- state, output, 3: current state code, used for the display banners.
- winner, output, 2: 00 = none, 01 = player 1, 10 = player 2.

## Operation
- **States and codes:** IDLE=0, SERVE=1, RALLY=2, PAUSE=3, POINT=4, OVER=5. Codes 6 and 7 go to IDLE on the next Clk.
- **Key edge detection:**
  - A key event is keycode==K this cycle and keycode!=K in the registered previous-cycle keycode.
  - A held key produces exactly one event.
  - A key pressed during Reset produces no event after Reset is released.
- **IDLE:** ball_reset=1, ball_run=0. On a SERVE_KEY event, go to SERVE.
- **SERVE:** ball_reset=1, ball_run=0. On the next frame_tick, go to RALLY.
- **RALLY:** ball_reset=0, ball_run=1. Each frame_tick, compare BallX:
  - BallX <= LEFT_GOAL: score2 increments, serve_dir <= 0, go to POINT.
  - Else if BallX >= RIGHT_GOAL: score1 increments, serve_dir <= 1, go to POINT.
  - The left check has priority.
  - A PAUSE_KEY event goes to PAUSE. If it coincides with a goal tick, the goal wins and the pause event is dropped.
- **PAUSE:** ball_reset=0, ball_run=0. BallX is ignored. A PAUSE_KEY event returns to RALLY. SERVE_KEY is ignored.
- **POINT:** ball_reset=0, ball_run=0, so the ball is frozen at the goal.
  - frame_cnt clears on entry and increments on each frame_tick.
  - On the frame_tick where frame_cnt==POINT_FRAMES-1:
    - If score1 or score2 equals WIN_SCORE, go to OVER and set winner.
    - Otherwise go to SERVE.
- **OVER:** ball_reset=1, ball_run=0, winner held.
  - A SERVE_KEY event clears both scores and winner, sets serve_dir to 0, and goes to SERVE.
- **Scores:**
  - 4-bit, saturating at 15.
  - Scores only change on a RALLY goal tick or an OVER restart.
- **Keys in other states:** SERVE_KEY in SERVE, RALLY or POINT is ignored. PAUSE_KEY outside RALLY and PAUSE is ignored.

## Timing
- All outputs are registered and change one Clk after the deciding input edge. There is no combinational input-to-output path.
- Reset values:
  - state=IDLE
  - ball_reset=1, ball_run=0
  - serve_dir=0
  - score1=0, score2=0
  - winner=00
  - frame_cnt=0
  - previous-keycode register=8'h00
- Reset asserted mid-operation in any state returns every register to its reset value on the next Clk edge. It overrides all events in the same cycle.
- Serve latency: SERVE_KEY event → SERVE one Clk later → RALLY on the Clk after the next frame_tick. The ball therefore leaves centre no earlier than the second frame after the key.
- Goal to resume: exactly POINT_FRAMES frame_ticks in POINT, then one frame_tick in SERVE.
- frame_tick is sampled only in RALLY, POINT and SERVE. Ticks in other states have no effect.

## Test plan
- **Serve:** Reset, then keycode 8'h2C for 3 cycles → state goes 0→1 once. On the next frame_tick, state=2, ball_run=1, ball_reset=0. Holding the key does not re-serve.
- **Left goal:** In RALLY with BallX=30 and a frame_tick → score2=1, serve_dir=0, state=4. Exactly 60 frame_ticks later, state=1 and ball_reset=1.
- **Right goal with priority:** In RALLY with BallX=600 and a frame_tick → score1=1, serve_dir=1. Goal tick coinciding with a PAUSE_KEY event → state=4, not PAUSE.
- **Pause:** In RALLY, press P → state=3, ball_run=0. Feed BallX=10 with 5 frame_ticks → no score change. Press P again → state=2.
- **Game over:** Drive score1 to 7 through goals → after the POINT hold, state=5 and winner=01. Press space → scores=0, winner=00, state=1.
- **Reset mid-POINT:** Assert Reset at frame_cnt=20 → next Clk: state=0, scores=0, ball_reset=1, frame_cnt=0.
